mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares the single 6-bit-block-address / 32-bit main memory between the instruction cache
//   (read-only port I) and the data cache (read/write port D). Serialises requests, holds the
//   grant for a whole memory transaction and returns per-port busywait and read data.
//   It sits between both cache controllers and the data memory model.
// PARAMETERS
//   ADDR_W     6   block address width (tag+index)
//   DATA_W     32  block width
//   PRIO_MODE  0   0 = round-robin on simultaneous requests; 1 = fixed priority, D over I
// PORTS
//   clk            in   1       clock, all state on rising edge
//   reset          in   1       asynchronous, active-low reset
//   i_read         in   1       I-cache block read request (level, held until busywait low)
//   i_address      in   ADDR_W  I-cache block address
//   i_readdata     out  DATA_W  block returned to I-cache
//   i_busywait     out  1       stall to I-cache
//   d_read         in   1       D-cache block read request
//   d_write        in   1       D-cache block write request
//   d_address      in   ADDR_W  D-cache block address
//   d_writedata    in   DATA_W  D-cache write-back block
//   d_readdata     out  DATA_W  block returned to D-cache
//   d_busywait     out  1       stall to D-cache
//   mem_read       out  1       memory read strobe (registered)
//   mem_write      out  1       memory write strobe (registered)
//   mem_address    out  ADDR_W  memory block address (registered)
//   mem_writedata  out  DATA_W  memory write data (registered)
//   mem_readdata   in   DATA_W  memory read data
//   mem_busywait   in   1       memory stall
// BEHAVIOUR
//   - Reset (reset==0, async): state IDLE; mem_read/mem_write=0; mem_address, mem_writedata,
//     i_readdata, d_readdata = 0; done pulses=0; round-robin pointer = I-next. In-flight memory
//     transaction abandoned; memory sees strobes drop immediately.
//   - x_busywait = (x_read | x_write) & ~x_done (combinational; x_done is a registered 1-cycle
//     pulse). Idle port with no request sees busywait=0.
//   - States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//     IDLE: if any request, pick winner; register mem_read/mem_write/mem_address/mem_writedata
//       from winner's inputs; -> ISSUE. No request: stay, strobes 0.
//     ISSUE: one cycle, strobes held so memory can raise mem_busywait; -> WAIT.
//     WAIT: strobes held; when mem_busywait==0 at clock edge: drop strobes, latch mem_readdata
//       into winner's x_readdata (reads only; writes leave x_readdata unchanged), set x_done; -> DONE.
//     DONE: x_done high for exactly this cycle (requester samples ~busywait here); clear x_done;
//       -> IDLE. Minimum transaction = 4 cycles grant-to-IDLE plus memory wait.
//   - Arbitration (PRIO_MODE 0): single requester always wins; both requesting -> port named by
//     pointer wins, pointer flips to other port after each grant completes.
//     PRIO_MODE 1: D wins whenever d_read|d_write; I only when D idle.
//   - d_read & d_write both high: treated as write; read ignored (protocol violation).
//   - Request inputs sampled only in IDLE; changes during ISSUE/WAIT ignored. Requester dropping
//     its request mid-transaction does not abort; transaction completes, result discarded.
//   - Loser keeps busywait high throughout; granted on next IDLE.
//   - Readdata outputs hold last value until next completed read for that port.
// CONFIGURATION
//   MEM_ARB_WB_LOCK_EN defined: after a D write completes, next IDLE grants D unconditionally if
//     d_read is high (write-back + refill atomic); pointer not advanced by the write, only by the
//     following read. If d_read low in that IDLE, lock released, normal arbitration.
//   Not defined: every IDLE arbitrates normally; I may be granted between D write-back and refill.
// TESTING
//   - Reset mid-WAIT (D read, addr 6'h15): reset low -> mem_read=0, d_busywait stays 1 while
//     d_read held, FSM IDLE; after release, request reissued to 6'h15.
//   - I read alone, addr 6'h0A, memory returns 32'hDEADBEEF after 5 busy cycles -> mem_read high
//     from grant to end, i_readdata=32'hDEADBEEF, i_busywait low exactly one cycle.
//   - I and D read same cycle, PRIO_MODE 0 -> I served first, then D; repeat -> D first, then I.
//     PRIO_MODE 1 -> D first both times.
//   - D write 6'h21 data 32'h12345678 -> mem_write=1, mem_address=6'h21, mem_writedata held
//     constant until mem_busywait low; d_readdata unchanged.
//   - D write-back 6'h21 then refill 6'h31 with I read 6'h02 pending: MEM_ARB_WB_LOCK_EN ->
//     order W21,R31,R02; without macro (pointer at I after D) -> W21,R02,R31.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache (read-only) and D-cache (read/write) ports onto one block memory.
// Optional build macro MEM_ARB_WB_LOCK_EN keeps a D write-back and its refill back to back.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e state_q;
  logic   grant_d_q;  // current transaction belongs to the D port
  logic   adv_q;      // completing this grant moves the round-robin pointer
  logic   rr_d_q;     // D wins the next contested grant
  logic   i_done_q;
  logic   d_done_q;

  logic i_req;
  logic d_req;
  logic contested;
  logic pick_d;
  logic adv_sel;

`ifdef MEM_ARB_WB_LOCK_EN
  logic lock_q;  // previous transaction was a D write; refill may follow
`endif

  assign i_req     = i_read;
  assign d_req     = d_read | d_write;
  assign contested = i_req & d_req;

  assign i_busywait = i_req & ~i_done_q;
  assign d_busywait = d_req & ~d_done_q;

  always_comb begin
    pick_d  = 1'b0;
    adv_sel = contested;
    if (PRIO_MODE == 1) begin
      pick_d = d_req;
    end else begin
      pick_d = d_req & (~i_req | rr_d_q);
    end
`ifdef MEM_ARB_WB_LOCK_EN
    if (lock_q && d_read) begin
      pick_d = 1'b1;
    end
    // A write-back leaves the pointer alone so the refill can claim the turn.
    if (pick_d && d_write) begin
      adv_sel = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      grant_d_q     <= 1'b0;
      adv_q         <= 1'b0;
      rr_d_q        <= 1'b0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
`ifdef MEM_ARB_WB_LOCK_EN
      lock_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
`ifdef MEM_ARB_WB_LOCK_EN
          lock_q <= 1'b0;
`endif
          if (i_req || d_req) begin
            grant_d_q <= pick_d;
            adv_q     <= adv_sel;
            if (pick_d) begin
              // Simultaneous read and write is resolved as a write.
              mem_write   <= d_write;
              mem_read    <= ~d_write;
              mem_address <= d_address;
              if (d_write) begin
                mem_writedata <= d_writedata;
              end
            end else begin
              mem_read    <= 1'b1;
              mem_write   <= 1'b0;
              mem_address <= i_address;
            end
            state_q <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (!mem_busywait) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) begin
              if (grant_d_q) begin
                d_readdata <= mem_readdata;
              end else begin
                i_readdata <= mem_readdata;
              end
            end
            if (grant_d_q) begin
              d_done_q <= 1'b1;
            end else begin
              i_done_q <= 1'b1;
            end
            if (adv_q) begin
              rr_d_q <= ~grant_d_q;
            end
`ifdef MEM_ARB_WB_LOCK_EN
            lock_q <= grant_d_q & mem_write;
`endif
            state_q <= StDone;
          end
        end
        StDone: begin
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
